// File: rtl/delay_chk.sv
// delay_chk: measures and checks the request-to-acknowledge delay of a delay_gen enable handshake
module delay_chk #(
    parameter int CYCLES      = 3,
    parameter int TOL         = 0,
    parameter int TIMEOUT     = 16,
    parameter int DROP_MAX    = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rtc_i,
    input  logic             en_req_i,
    input  logic             en_ack_i,
    output logic [CNT_W-1:0] meas_o,
    output logic             meas_valid_o,
    output logic             early_o,
    output logic             late_o,
    output logic             timeout_o,
    output logic             glitch_o,
    output logic             drop_err_o,
    output logic             busy_o
);
    typedef enum logic [2:0] {IDLE, WAIT_ACK, ACTIVE, WAIT_DROP, HOLD} state_t;

    localparam int LO = CYCLES - TOL;
    localparam int HI = CYCLES + TOL;
    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DROP_V = CNT_W'(DROP_MAX);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q, req_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d, dcnt_q, dcnt_d, meas_q, meas_d;
    logic                   mv_q, mv_d, early_q, early_d, late_q, late_d;
    logic                   to_q, to_d, glitch_q, glitch_d, drop_q, drop_d;
    logic                   rtc_edge, req_rise;
    logic [CNT_W-1:0]       cnt_sat;

    assign rtc_edge = sync_q[SYNC_STAGES-1] & ~last_q;
    assign req_rise = en_req_i & ~req_q;
    assign cnt_sat  = (rtc_edge && cnt_q != '1) ? cnt_q + ONE : cnt_q;

    // rtc synchronizer, rtc edge detector and request history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            last_q <= 1'b0;
            req_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rtc_i};
            last_q <= sync_q[SYNC_STAGES-1];
            req_q  <= en_req_i;
        end
    end

    // handshake state machine: next state, counters and registered pulse values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        meas_d   = meas_q;
        mv_d     = 1'b0;
        early_d  = 1'b0;
        late_d   = 1'b0;
        to_d     = 1'b0;
        glitch_d = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                glitch_d = en_ack_i & (~en_req_i | req_rise);
                if (req_rise) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            WAIT_ACK: begin
                if (en_ack_i) begin
                    meas_d  = cnt_q;
                    mv_d    = 1'b1;
                    early_d = (LO > 0) && (int'(cnt_q) < LO);
                    late_d  = int'(cnt_q) > HI;
                    state_d = ACTIVE;
                end else if (!en_req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_V) begin
                    to_d    = 1'b1;
                    meas_d  = TO_V;
                    mv_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            ACTIVE: begin
                if (!en_req_i) begin
                    state_d = WAIT_DROP;
                    dcnt_d  = '0;
                end else if (!en_ack_i) begin
                    glitch_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            WAIT_DROP: begin
                if (!en_ack_i) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                    if (dcnt_d == DROP_V) begin
                        drop_d  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: state_d = (!en_req_i && !en_ack_i) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            meas_q   <= '0;
            mv_q     <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            to_q     <= 1'b0;
            glitch_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            meas_q   <= meas_d;
            mv_q     <= mv_d;
            early_q  <= early_d;
            late_q   <= late_d;
            to_q     <= to_d;
            glitch_q <= glitch_d;
            drop_q   <= drop_d;
        end
    end

    assign meas_o       = meas_q;
    assign meas_valid_o = mv_q;
    assign early_o      = early_q;
    assign late_o       = late_q;
    assign timeout_o    = to_q;
    assign glitch_o     = glitch_q;
    assign drop_err_o   = drop_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: doc/delay_chk.md
# delay_chk

Protocol-side checker for the `delay_gen` enable handshake. It watches the request enable fed to a delay generator and the delayed enable that comes back. It counts reference-clock (`rtc_i`) rising edges between the request rising and the acknowledge rising, and reports that count. It flags early, late, missing (timeout) and spurious acknowledges. It sits next to each `delay_gen` instance in the power/enable sequencing path and feeds the status/interrupt logic.

## Interface
- `CYCLES`, 3: expected number of rtc rising edges from request rise to acknowledge rise.
- `TOL`, 0: allowed deviation from `CYCLES` in rtc edges, either side.
- `TIMEOUT`, 16: number of rtc edges in WAIT_ACK after which the acknowledge is declared missing. Must be greater than `CYCLES+TOL`.
- `DROP_MAX`, 4: number of clk_i cycles allowed for the acknowledge to fall after the request falls.
- `CNT_W`, 8: width of the measurement counter. Must satisfy 2^CNT_W > TIMEOUT.
- `SYNC_STAGES`, 2: depth of the rtc_i synchronizer (≥2).

Ports:
- `clk_i`  in  1  block clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `rtc_i`  in  1  reference clock, asynchronous to clk_i.
- `en_req_i`  in  1  request enable (delay_gen input), synchronous to clk_i.
- `en_ack_i`  in  1  delayed enable (delay_gen output), synchronous to clk_i.
- `meas_o`  out  CNT_W  last measured rtc-edge count; holds until the next measurement.
- `meas_valid_o`  out  1  one-cycle pulse when `meas_o` updates.
- `early_o`, `late_o`, `timeout_o`, `glitch_o`, `drop_err_o`  out  1 each  one-cycle error pulses.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- rtc path: `rtc_i` passes through `SYNC_STAGES` flops, then a last-sample flop.
  - `rtc_edge` = synced & ~last.
- `req_q` registers `en_req_i`.
  - `req_rise` = en_req_i & ~req_q.
  - `req_fall` = ~en_req_i & req_q.
- State machine, states IDLE, WAIT_ACK, ACTIVE, WAIT_DROP, HOLD:
  - **IDLE:**
    - On `req_rise`, go to WAIT_ACK and clear `cnt`.
    - If `en_ack_i`=1 while `en_req_i`=0, pulse `glitch_o`.
  - **WAIT_ACK:**
    - `rtc_edge` increments `cnt`. The count saturates at all-ones.
    - If `en_ack_i`=1, load `meas_o` with `cnt` and pulse `meas_valid_o`.
      - If `cnt` < CYCLES−TOL (signed compare, floor 0), also pulse `early_o`.
      - If `cnt` > CYCLES+TOL, also pulse `late_o`.
      - Then go to ACTIVE.
    - Else if `en_req_i`=0 (abort), go to IDLE. No measurement and no error.
    - Else if `cnt` = TIMEOUT, pulse `timeout_o`, load `meas_o` with TIMEOUT, pulse `meas_valid_o`, and go to HOLD.
  - **ACTIVE:**
    - If `en_req_i`=0, go to WAIT_DROP and clear `dcnt`.
    - Else if `en_ack_i`=0, pulse `glitch_o` and go to HOLD.
  - **WAIT_DROP:**
    - If `en_ack_i`=0, go to IDLE.
    - Else `dcnt` increments each cycle.
    - When `dcnt` = DROP_MAX, pulse `drop_err_o` and go to HOLD.
  - **HOLD:** stay until `en_req_i`=0 and `en_ack_i`=0 in the same cycle, then go to IDLE.
- Simultaneous events in WAIT_ACK:
  - Acknowledge and `rtc_edge` in the same cycle: the measurement uses `cnt` before the increment.
  - Acknowledge beats timeout, and timeout beats nothing else.
  - Abort (request low) wins over timeout.
- A request rise in IDLE with `en_ack_i` already high is still a request. `glitch_o` pulses in that cycle, and the FSM goes to WAIT_ACK. The acknowledge is then taken in the next cycle, so `cnt`=0 and `early_o` pulses if CYCLES−TOL > 0.

## Timing
- Reset values:
  - FSM in IDLE; `cnt`=0, `dcnt`=0.
  - `meas_o`=0 and all pulse outputs 0; `busy_o`=0.
  - Sync flops and last-sample flop 0.
  - `req_q`=1, so a request already high when reset releases is not measured.
- Reset mid-operation: abandon the measurement immediately. No pulses are issued during or in the cycle after reset.
- rtc latency: an `rtc_i` rise is counted SYNC_STAGES+1 clk_i cycles later. rtc high and low phases must each be at least SYNC_STAGES+1 clk_i periods.
- Output latency: pulses and `meas_o` update one clk_i cycle after the acknowledge, timeout or drop condition is sampled. They are registered outputs.
- `busy_o` rises the cycle after `req_rise` and falls the cycle after IDLE is entered.

## Test plan
- Nominal (CYCLES=3, TOL=0): request rises; the acknowledge rises after the 3rd counted rtc edge. Expect `meas_o`=3, one `meas_valid_o` pulse, no error pulses. Request falls; acknowledge falls 1 cycle later; expect IDLE and no `drop_err_o`.
- Early/late: acknowledge after 2 edges → `meas_o`=2 and `early_o`. Acknowledge after 5 edges → `meas_o`=5 and `late_o`.
- Timeout: acknowledge held low for 16 rtc edges → `timeout_o`, `meas_o`=16, FSM in HOLD. Drive request low → IDLE.
- Abort and glitch:
  - Request falls after 1 edge → no pulses, IDLE.
  - Acknowledge pulses while request low → `glitch_o`.
  - Acknowledge drops while request high in ACTIVE → `glitch_o`, then HOLD.
- Drop error and reset: acknowledge stays high 4 cycles after the request falls → `drop_err_o`. Separately, assert `rst_i` in WAIT_ACK with the request high → after release, no measurement until a new request rise.
- Edge coincidence: acknowledge and `rtc_edge` in the same cycle with `cnt`=2 → `meas_o`=2 and `early_o`.
